// File: rtl/booth_seq_sched.sv
// ============================================================================
// Module   : booth_seq_sched
// Brief    : Sequential signed WxW multiplier scheduler that time-shares one
//            external radix-4 Booth partial-product generator (booth_pp).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_seq_sched #(
   parameter int W    = 16,
   parameter int PIPE = 0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_x,
   input  logic [W-1:0]   in_y,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] out_prod,
   output logic           busy,
   output logic [W-1:0]   pp_y,
   output logic [2:0]     pp_booth_bits,
   input  logic [W:0]     pp,
   input  logic           cpl
);

   localparam int N  = W / 2;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int AW = 2 * W;

   if (W < 4 || (W % 2) != 0) begin : g_bad_w
      $error("booth_seq_sched: W must be even and >= 4");
   end
   if (PIPE < 0 || PIPE > 4) begin : g_bad_pipe
      $error("booth_seq_sched: PIPE must be in 0..4");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    x_q, x_d;
   logic [W-1:0]    y_q, y_d;
   logic [AW-1:0]   acc_q, acc_d;
   logic [CW-1:0]   issue_cnt_q, issue_cnt_d;
   logic [CW-1:0]   ret_cnt_q, ret_cnt_d;

   logic            w_issue;
   logic            w_ret_valid;
   logic [W:0]      w_x_ext;
   logic [2:0]      w_digit;
   logic [AW-1:0]   w_term;
   logic            w_last_issue;
   logic            w_last_ret;

   assign w_issue      = (state_q == S_ISSUE);
   // x[-1] = 0 is supplied by the appended zero, so digit j starts at bit 2j.
   assign w_x_ext      = {x_q, 1'b0};
   assign w_digit      = w_x_ext[{issue_cnt_q, 1'b0} +: 3];
   assign w_term       = {{(W-1){pp[W]}}, pp} + AW'(cpl);
   assign w_last_issue = (issue_cnt_q == CW'(N - 1));
   assign w_last_ret   = (ret_cnt_q == CW'(N - 1));

   // Returns are tracked by a valid token that travels alongside the generator
   // pipeline, so an aborted job leaves nothing behind once this clears.
   if (PIPE == 0) begin : g_ret_comb
      assign w_ret_valid = w_issue;
   end else begin : g_ret_pipe
      logic [PIPE-1:0] vld_q;
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            vld_q <= '0;
         end else begin
            vld_q <= (vld_q << 1) | PIPE'(w_issue);
         end
      end
      assign w_ret_valid = vld_q[PIPE-1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         acc_q       <= '0;
         issue_cnt_q <= '0;
         ret_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         acc_q       <= acc_d;
         issue_cnt_q <= issue_cnt_d;
         ret_cnt_q   <= ret_cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      y_d           = y_q;
      acc_d         = acc_q;
      issue_cnt_d   = issue_cnt_q;
      ret_cnt_d     = ret_cnt_q;
      in_ready      = 1'b0;
      out_valid     = 1'b0;
      busy          = (state_q != S_IDLE);
      out_prod      = acc_q;
      pp_y          = y_q;
      pp_booth_bits = 3'b000;

      if (w_ret_valid) begin
         acc_d     = acc_q + (w_term << {ret_cnt_q, 1'b0});
         ret_cnt_d = ret_cnt_q + CW'(1);
      end

      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               x_d         = in_x;
               y_d         = in_y;
               acc_d       = '0;
               issue_cnt_d = '0;
               ret_cnt_d   = '0;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            pp_booth_bits = w_digit;
            issue_cnt_d   = issue_cnt_q + CW'(1);
            if (w_last_issue) begin
               state_d = (PIPE > 0) ? S_DRAIN : S_DONE;
            end
         end
         S_DRAIN: begin
            if (w_ret_valid && w_last_ret) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_booth_seq_sched.sv
// ============================================================================
// Module   : tb_booth_seq_sched
// Brief    : Directed and randomised bench for booth_seq_sched with a
//            behavioural pipelined Booth generator attached to each instance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_seq_sched;

   logic clk;
   int   checks;
   int   errors;

   // W=8 instances: index 0 -> PIPE 0, 1 -> PIPE 2, 2 -> PIPE 1
   logic        rst8  [3];
   logic        iv8   [3];
   logic        ir8   [3];
   logic        ov8   [3];
   logic        or8   [3];
   logic        busy8 [3];
   logic [7:0]  x8    [3];
   logic [7:0]  y8    [3];
   logic [7:0]  ppy8  [3];
   logic [2:0]  bb8   [3];
   logic [15:0] prod8 [3];

   // W=16 instances: index 0 -> PIPE 0, 1 -> PIPE 1, 2 -> PIPE 3
   logic        rst16;
   logic        iv16   [3];
   logic        ir16   [3];
   logic        ov16   [3];
   logic        or16   [3];
   logic        busy16 [3];
   logic [15:0] x16    [3];
   logic [15:0] y16    [3];
   logic [15:0] ppy16  [3];
   logic [2:0]  bb16   [3];
   logic [31:0] prod16 [3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference generator: returns {cpl, pp} for a 16-bit (pre-sign-extended) y.
   function automatic logic [17:0] booth_model(input logic [15:0] y, input logic [2:0] b);
      logic signed [16:0] ys;
      logic signed [16:0] mult;
      logic               neg;
      ys = {y[15], y};
      case (b)
         3'b001, 3'b010, 3'b101, 3'b110: mult = ys;
         3'b011, 3'b100:                 mult = ys <<< 1;
         default:                        mult = '0;
      endcase
      neg = (b == 3'b100) || (b == 3'b101) || (b == 3'b110);
      return {neg, neg ? ~mult : mult};
   endfunction

   for (genvar k = 0; k < 3; k++) begin : g_w8
      localparam int P = (k == 0) ? 0 : ((k == 1) ? 2 : 1);
      logic [17:0] m;
      logic [9:0]  s0;
      logic [39:0] sr;
      logic [49:0] chain;
      logic [9:0]  sel;
      always_comb m = booth_model({{8{ppy8[k][7]}}, ppy8[k]}, bb8[k]);
      assign s0    = {m[17], m[8:0]};
      always @(posedge clk) sr <= {sr[29:0], s0};
      assign chain = {sr, s0};
      assign sel   = chain[10*P +: 10];
      booth_seq_sched #(.W(8), .PIPE(P)) u_dut (
         .clk(clk), .rst(rst8[k]), .in_valid(iv8[k]), .in_ready(ir8[k]),
         .in_x(x8[k]), .in_y(y8[k]), .out_valid(ov8[k]), .out_ready(or8[k]),
         .out_prod(prod8[k]), .busy(busy8[k]), .pp_y(ppy8[k]),
         .pp_booth_bits(bb8[k]), .pp(sel[8:0]), .cpl(sel[9])
      );
   end

   for (genvar k = 0; k < 3; k++) begin : g_w16
      localparam int P = (k == 0) ? 0 : ((k == 1) ? 1 : 3);
      logic [17:0] s0;
      logic [71:0] sr;
      logic [89:0] chain;
      logic [17:0] sel;
      always_comb s0 = booth_model(ppy16[k], bb16[k]);
      always @(posedge clk) sr <= {sr[53:0], s0};
      assign chain = {sr, s0};
      assign sel   = chain[18*P +: 18];
      booth_seq_sched #(.W(16), .PIPE(P)) u_dut (
         .clk(clk), .rst(rst16), .in_valid(iv16[k]), .in_ready(ir16[k]),
         .in_x(x16[k]), .in_y(y16[k]), .out_valid(ov16[k]), .out_ready(or16[k]),
         .out_prod(prod16[k]), .busy(busy16[k]), .pp_y(ppy16[k]),
         .pp_booth_bits(bb16[k]), .pp(sel[16:0]), .cpl(sel[17])
      );
   end

   task automatic test_reset();
      #3;
      for (int k = 0; k < 3; k++) begin
         checks++; if (ir8[k] !== 1'b1) begin errors++; $display("FAIL reset_in_ready8[%0d] got %b want 1", k, ir8[k]); end
         checks++; if (ov8[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid8[%0d] got %b want 0", k, ov8[k]); end
         checks++; if (prod8[k] !== 16'h0) begin errors++; $display("FAIL reset_prod8[%0d] got %h want 0000", k, prod8[k]); end
         checks++; if (busy8[k] !== 1'b0) begin errors++; $display("FAIL reset_busy8[%0d] got %b want 0", k, busy8[k]); end
         checks++; if (ppy8[k] !== 8'h0) begin errors++; $display("FAIL reset_pp_y8[%0d] got %h want 00", k, ppy8[k]); end
         checks++; if (bb8[k] !== 3'b000) begin errors++; $display("FAIL reset_bits8[%0d] got %b want 000", k, bb8[k]); end
         checks++; if (ir16[k] !== 1'b1 || ov16[k] !== 1'b0) begin
            errors++; $display("FAIL reset_16[%0d] got ready=%b valid=%b want 1/0", k, ir16[k], ov16[k]);
         end
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) rst8[k] = 1'b1;
      rst16 = 1'b1;
   endtask

   task automatic run8(input int k, input logic [7:0] x, input logic [7:0] y,
                       input logic [15:0] exp, input int exp_lat, input string nm);
      int lat;
      @(negedge clk);
      iv8[k] = 1'b1; x8[k] = x; y8[k] = y; or8[k] = 1'b0;
      checks++; if (ir8[k] !== 1'b1) begin errors++; $display("FAIL %s ready_before got %b want 1", nm, ir8[k]); end
      @(posedge clk); #1;
      iv8[k] = 1'b0;
      lat = 0;
      while (ov8[k] !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL %s latency got %0d want %0d", nm, lat, exp_lat); end
      checks++; if (prod8[k] !== exp) begin errors++; $display("FAIL %s product got %h want %h", nm, prod8[k], exp); end
      @(negedge clk); or8[k] = 1'b1;
      @(posedge clk); #1; or8[k] = 1'b0;
      checks++; if (ir8[k] !== 1'b1 || ov8[k] !== 1'b0) begin
         errors++; $display("FAIL %s after_handshake got ready=%b valid=%b want 1/0", nm, ir8[k], ov8[k]);
      end
   endtask

   task automatic test_pipe0_basic();
      run8(0, 8'd3, 8'd5, 16'h000F, 4, "p0_3x5");
   endtask

   task automatic test_pipe2_extremes();
      run8(1, 8'h80, 8'h80, 16'h4000, 6, "p2_min_x_min");
      run8(1, 8'h7F, 8'h80, 16'hC080, 6, "p2_max_x_min");
   endtask

   task automatic test_pipe1_bits();
      run8(2, 8'h00, 8'h55, 16'h0000, 5, "p1_zero");
      @(negedge clk);
      checks++; if (bb8[2] !== 3'b000) begin errors++; $display("FAIL p1_bits_idle got %b want 000", bb8[2]); end
      iv8[2] = 1'b1; x8[2] = 8'hFF; y8[2] = 8'hFF;
      @(posedge clk); #1; iv8[2] = 1'b0;
      checks++; if (bb8[2] !== 3'b110) begin errors++; $display("FAIL p1_bits_digit0 got %b want 110", bb8[2]); end
      repeat (3) begin @(posedge clk); #1; end
      checks++; if (bb8[2] !== 3'b111) begin errors++; $display("FAIL p1_bits_digit3 got %b want 111", bb8[2]); end
      @(posedge clk); #1;
      checks++; if (bb8[2] !== 3'b000 || busy8[2] !== 1'b1 || ov8[2] !== 1'b0) begin
         errors++; $display("FAIL p1_drain got bits=%b busy=%b valid=%b want 000/1/0", bb8[2], busy8[2], ov8[2]);
      end
      @(posedge clk); #1;
      checks++; if (ov8[2] !== 1'b1 || prod8[2] !== 16'h0001 || bb8[2] !== 3'b000) begin
         errors++; $display("FAIL p1_done got valid=%b prod=%h bits=%b want 1/0001/000", ov8[2], prod8[2], bb8[2]);
      end
      @(negedge clk); or8[2] = 1'b1;
      @(posedge clk); #1; or8[2] = 1'b0;
      checks++; if (ir8[2] !== 1'b1) begin errors++; $display("FAIL p1_return_idle got %b want 1", ir8[2]); end
   endtask

   task automatic test_backpressure();
      int w;
      @(negedge clk);
      iv8[0] = 1'b1; x8[0] = 8'h07; y8[0] = 8'hFD; or8[0] = 1'b0;
      @(posedge clk); #1; iv8[0] = 1'b0;
      w = 0;
      while (ov8[0] !== 1'b1 && w < 40) begin @(posedge clk); #1; w++; end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         iv8[0] = (i % 2 == 0); x8[0] = 8'h11; y8[0] = 8'h22;
         checks++; if (ov8[0] !== 1'b1 || prod8[0] !== 16'hFFEB || ir8[0] !== 1'b0) begin
            errors++; $display("FAIL bp_hold[%0d] got valid=%b prod=%h ready=%b want 1/ffeb/0", i, ov8[0], prod8[0], ir8[0]);
         end
      end
      @(negedge clk); iv8[0] = 1'b0; or8[0] = 1'b1;
      @(posedge clk); #1; or8[0] = 1'b0;
      checks++; if (ir8[0] !== 1'b1 || busy8[0] !== 1'b0 || ov8[0] !== 1'b0) begin
         errors++; $display("FAIL bp_release got ready=%b busy=%b valid=%b want 1/0/0", ir8[0], busy8[0], ov8[0]);
      end
   endtask

   task automatic test_reset_abort();
      @(negedge clk);
      iv8[1] = 1'b1; x8[1] = 8'h5A; y8[1] = 8'h33;
      @(posedge clk); #1; iv8[1] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (busy8[1] !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b want 1", busy8[1]); end
      rst8[1] = 1'b0;
      @(negedge clk); rst8[1] = 1'b1;
      @(posedge clk); #1;
      checks++; if (ir8[1] !== 1'b1 || busy8[1] !== 1'b0 || ov8[1] !== 1'b0 || bb8[1] !== 3'b000) begin
         errors++; $display("FAIL abort_after got ready=%b busy=%b valid=%b bits=%b want 1/0/0/000", ir8[1], busy8[1], ov8[1], bb8[1]);
      end
      repeat (4) begin @(posedge clk); #1; end
      checks++; if (ov8[1] !== 1'b0 || busy8[1] !== 1'b0 || prod8[1] !== 16'h0) begin
         errors++; $display("FAIL abort_no_product got valid=%b busy=%b prod=%h want 0/0/0000", ov8[1], busy8[1], prod8[1]);
      end
      run8(1, 8'd9, 8'd9, 16'h0051, 6, "abort_next_9x9");
   endtask

   task automatic sweep16(input int k);
      logic [15:0]        x, y;
      logic signed [31:0] xs, ys, e;
      int                 w;
      bit                 done;
      for (int n = 0; n < 1000; n++) begin
         if (n == 0) begin x = 16'h8000; y = 16'h8000; end
         else if (n == 1) begin x = 16'h7FFF; y = 16'h8000; end
         else begin x = 16'($urandom); y = 16'($urandom); end
         xs = $signed(x); ys = $signed(y); e = xs * ys;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         @(negedge clk);
         iv16[k] = 1'b1; x16[k] = x; y16[k] = y;
         w = 0;
         while (ir16[k] !== 1'b1 && w < 20) begin @(negedge clk); w++; end
         if (w >= 20) begin
            checks++; errors++;
            $display("FAIL sweep%0d job %0d accept timeout got ready=%b want 1", k, n, ir16[k]);
            iv16[k] = 1'b0;
            break;
         end
         @(posedge clk); #1;
         iv16[k] = 1'b0; x16[k] = 16'($urandom); y16[k] = 16'($urandom);
         w = 0; done = 1'b0;
         while (!done && w < 60) begin
            @(negedge clk);
            or16[k] = 1'($urandom_range(0, 1));
            if (ov16[k] === 1'b1 && or16[k] === 1'b1) done = 1'b1;
            w++;
         end
         checks++;
         if (!done || prod16[k] !== e) begin
            errors++;
            $display("FAIL sweep%0d job %0d x=%h y=%h got %h (valid seen %0d) want %h", k, n, x, y, prod16[k], done, e);
         end
         @(posedge clk); #1; or16[k] = 1'b0;
      end
   endtask

   task automatic test_sweep();
      fork
         sweep16(0);
         sweep16(1);
         sweep16(2);
      join
   endtask

   initial begin
      #900000;
      $display("FAIL global_timeout got no finish want finish before 900000");
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst16  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         rst8[k] = 1'b0; iv8[k] = 1'b0; or8[k] = 1'b0; x8[k] = '0; y8[k] = '0;
         iv16[k] = 1'b0; or16[k] = 1'b0; x16[k] = '0; y16[k] = '0;
      end
      test_reset();
      test_pipe0_basic();
      test_pipe2_extremes();
      test_pipe1_bits();
      test_backpressure();
      test_reset_abort();
      test_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/booth_seq_sched.md
Name: booth_seq_sched

Overview:
- Sequential scheduler that computes a signed W×W multiply by time-sharing one radix-4 Booth partial-product generator (the booth_pp datapath; ports y, booth_bits, pp, cpl; parameters W, PIPE).
- Accepts operands on a valid/ready input and issues one Booth digit per cycle to the shared generator.
- Aligns returning partial products to the generator's PIPE latency and accumulates them. Presents the 2W-bit product on a valid/ready output.
- Sits between the operand source and the shared booth_pp instance; the generator itself is external.

Parameters:
- W, 16, operand width. Must be even and ≥4; elaboration error otherwise.
- PIPE, 0, register stages in the attached booth_pp instance (0 = combinational). Legal range 0..4.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  scheduler can accept operands.
- in_x  input  W  multiplicand/recoded operand, two's complement.
- in_y  input  W  multiple source, two's complement.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- out_prod  output  2W  signed product in_x·in_y.
- busy  output  1  high whenever state ≠ IDLE.
- pp_y  output  W  to booth_pp y.
- pp_booth_bits  output  3  to booth_pp booth_bits.
- pp  input  W+1  from booth_pp.
- cpl  input  1  from booth_pp.

Behaviour:
- N = W/2 digits. Digit j = {x[2j+1], x[2j], x[2j-1]}, with x[-1] = 0.
- Partial-product convention: value of a returned digit = signed(pp) + cpl. pp is the selected multiple (0, ±y, ±2y), bit-inverted when negative.
- Reset (rst=0, asynchronous): state = IDLE, in_ready=1, out_valid=0, out_prod=0, busy=0, pp_y=0, pp_booth_bits=000, accumulator=0, all counters=0.
- States:
  - IDLE: in_ready=1. On in_valid·in_ready: latch x and y, clear the accumulator, issue_cnt=0, ret_cnt=0, go to ISSUE.
  - ISSUE: drive pp_y = latched y and pp_booth_bits = digit issue_cnt; increment issue_cnt each cycle. After digit N-1 is driven: go to DRAIN if PIPE>0, else go to DONE.
  - DRAIN: pp_booth_bits=000, pp_y held. Wait until the final return is sampled, then go to DONE.
  - DONE: out_valid=1 and out_prod = accumulator. On out_valid·out_ready, go to IDLE.
- pp_booth_bits = 000 in every state except ISSUE. pp_y holds its last value outside ISSUE/DRAIN.
- Return alignment: the digit driven in the cycle after edge T0+j is sampled at edge T0+j+PIPE+1. Implement as a PIPE-deep valid shift register; do not predict from counters.
- Each sampled return: acc ← acc + (sext_2W(pp) + cpl) << (2·ret_cnt), modulo 2^2W; then ret_cnt++.
- Latency: out_valid rises exactly N+PIPE cycles after the accept edge T0. Example: W=16, PIPE=1 gives 9 cycles.
- Backpressure: in DONE with out_ready=0, out_prod and out_valid are held stable indefinitely; in_ready=0.
- Back-to-back: in_ready returns one cycle after the output handshake (one IDLE bubble). There is no overlap of jobs.
- in_valid outside IDLE is ignored; in_x and in_y are not sampled.
- Reset asserted mid-operation aborts the job: all state returns to reset values and no product is emitted. Generator pipeline contents are discarded, since the valid shift register clears.
- Full-range correctness is required, including x = y = -2^(W-1).

Test Plan:
- W=8, PIPE=0: x=3, y=5 → out_prod=0x000F, out_valid 4 cycles after accept.
- W=8, PIPE=2: x=-128, y=-128 → 0x4000, 6 cycles. x=127, y=-128 → 0xC080.
- W=8, PIPE=1: x=0, y=0x55 → 0x0000. Separately, x=-1, y=-1 → 0x0001. Check pp_booth_bits=000 outside ISSUE.
- Backpressure: x=7, y=-3 with out_ready low for 5 cycles → out_prod=0xFFEB held stable; in_ready=0 and in_valid pulses ignored; IDLE entered the cycle after out_ready=1.
- Reset during ISSUE digit 2 → next cycle in_ready=1, busy=0, out_valid=0. Following job x=9, y=9 → 0x0051.
- Random sweep: 1000 operand pairs at W=16 and PIPE∈{0,1,3}, random in_valid and out_ready → every product matches the signed reference; outputs appear in order.
